// File: rtl/sad_pkg.sv
// sad_pkg: shared types and widths for the SAD motion-search blocks
package sad_pkg;
  localparam int SAD_W = 32;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_e;
endpackage

// File: rtl/sad_min_cmp.sv
// sad_min_cmp: decides whether a new sad replaces the current best
module sad_min_cmp
  import sad_pkg::*;
#(
  parameter int W = SAD_W
) (
  input  logic [W-1:0] sad,
  input  logic [W-1:0] best_sad,
  input  logic         first,
  output logic         take
);
  assign take = first | (sad < best_sad);
endmodule

// File: rtl/sad_best_match.sv
// sad_best_match: sequences N_CAND SAD runs and tracks the minimum sad and its index
module sad_best_match
  import sad_pkg::*;
#(
  parameter int N_CAND = 16,
  parameter int SAD_W = sad_pkg::SAD_W,
  localparam int IDX_W = $clog2(N_CAND)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             sad_go,
  output logic [IDX_W-1:0] cand_idx,
  input  logic             sad_done,
  input  logic [SAD_W-1:0] sad,
  output logic [SAD_W-1:0] best_sad,
  output logic [IDX_W-1:0] best_idx,
  output logic             busy,
  output logic             done
);
  state_e state_q, state_d;
  logic [IDX_W-1:0] cand_q, cand_d, best_idx_q, best_idx_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d;
  logic first_q, first_d, take, last;
  sad_min_cmp #(.W(SAD_W)) u_cmp (
    .sad(sad),
    .best_sad(best_sad_q),
    .first(first_q),
    .take(take)
  );
  assign last = cand_q == IDX_W'(N_CAND - 1);
  always_comb begin
    state_d = state_q;
    cand_d = cand_q;
    best_sad_d = best_sad_q;
    best_idx_d = best_idx_q;
    first_d = first_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ISSUE;
        cand_d = '0;
        first_d = 1'b1;
        best_sad_d = '0;
        best_idx_d = '0;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (sad_done) begin
        best_sad_d = take ? sad : best_sad_q;
        best_idx_d = take ? cand_q : best_idx_q;
        first_d = 1'b0;
        state_d = last ? FIN : ISSUE;
        cand_d = last ? cand_q : cand_q + IDX_W'(1);
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cand_q <= '0;
      best_sad_q <= '0;
      best_idx_q <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      best_sad_q <= best_sad_d;
      best_idx_q <= best_idx_d;
      first_q <= first_d;
    end
  end
  assign sad_go = state_q == ISSUE;
  assign done = state_q == FIN;
  assign busy = state_q != IDLE;
  assign cand_idx = cand_q;
  assign best_sad = best_sad_q;
  assign best_idx = best_idx_q;
endmodule

// File: tb/tb_sad_best_match.sv
// tb_sad_best_match: directed checks of the search sequencer with an L=3 SAD engine model
module tb_sad_best_match;
  localparam int N = 4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sad_done = 1'b0;
  logic [31:0] sad = '0;
  logic sad_go, busy, done;
  logic [1:0] cand_idx, best_idx;
  logic [31:0] best_sad;
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  sad_best_match #(.N_CAND(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .sad_go(sad_go),
    .cand_idx(cand_idx),
    .sad_done(sad_done),
    .sad(sad),
    .best_sad(best_sad),
    .best_idx(best_idx),
    .busy(busy),
    .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask
  task automatic search(input logic [31:0] s [N], input logic [31:0] exp_sad,
                        input logic [1:0] exp_idx, input bit spur, input int rst_at);
    int cyc, n;
    start = 1'b1;
    if (spur) begin
      sad_done = 1'b1;
      sad = 32'h0;
    end
    @(negedge clk);
    start = 1'b0;
    sad_done = 1'b0;
    cyc = 1;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("best_sad_cleared", best_sad, 32'd0);
    chk("best_idx_cleared", {30'b0, best_idx}, 32'd0);
    for (int i = 0; i < N; i++) begin
      n = 0;
      while (!sad_go && n < 20) begin
        @(negedge clk);
        cyc++;
        n++;
      end
      chk("sad_go", {31'b0, sad_go}, 32'd1);
      chk("cand_idx", {30'b0, cand_idx}, i);
      if (spur) begin
        sad_done = 1'b1;
        sad = 32'h0;
      end
      @(negedge clk);
      cyc++;
      sad_done = 1'b0;
      chk("go_one_cycle", {31'b0, sad_go}, 32'd0);
      if (i == rst_at) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_best_sad", best_sad, 32'd0);
        chk("rst_best_idx", {30'b0, best_idx}, 32'd0);
        chk("rst_cand_idx", {30'b0, cand_idx}, 32'd0);
        @(negedge clk);
        sad_done = 1'b1;
        sad = 32'd1;
        @(negedge clk);
        sad_done = 1'b0;
        chk("late_done_busy", {31'b0, busy}, 32'd0);
        chk("late_done_go", {31'b0, sad_go}, 32'd0);
        chk("late_done_best", best_sad, 32'd0);
        return;
      end
      if (spur) start = 1'b1;
      @(negedge clk);
      cyc++;
      start = 1'b0;
      repeat (2) begin
        @(negedge clk);
        cyc++;
      end
      sad_done = 1'b1;
      sad = s[i];
      @(negedge clk);
      cyc++;
      sad_done = 1'b0;
    end
    chk("done", {31'b0, done}, 32'd1);
    chk("busy_in_fin", {31'b0, busy}, 32'd1);
    chk("latency", cyc, 32'd21);
    chk("best_sad", best_sad, exp_sad);
    chk("best_idx", {30'b0, best_idx}, {30'b0, exp_idx});
    chk("cand_idx_fin", {30'b0, cand_idx}, 32'd3);
    @(negedge clk);
    chk("done_pulse", {31'b0, done}, 32'd0);
    chk("busy_idle", {31'b0, busy}, 32'd0);
    chk("best_sad_hold", best_sad, exp_sad);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy0", {31'b0, busy}, 32'd0);
    chk("rst_go0", {31'b0, sad_go}, 32'd0);
    chk("rst_done0", {31'b0, done}, 32'd0);
    chk("rst_best0", best_sad, 32'd0);
    chk("rst_cand0", {30'b0, cand_idx}, 32'd0);
    rst_n = 1'b1;
    sad_done = 1'b1;
    sad = 32'd7;
    @(negedge clk);
    sad_done = 1'b0;
    chk("idle_done_best", best_sad, 32'd0);
    chk("idle_done_busy", {31'b0, busy}, 32'd0);
    search('{32'd500, 32'd200, 32'd300, 32'd900}, 32'd200, 2'd1, 1'b0, -1);
    search('{32'd4, 32'd3, 32'd2, 32'd1}, 32'd1, 2'd3, 1'b0, -1);
    search('{32'd70, 32'd70, 32'd50, 32'd50}, 32'd50, 2'd2, 1'b0, -1);
    sad_done = 1'b1;
    sad = 32'd0;
    @(negedge clk);
    sad_done = 1'b0;
    chk("idle_spur_best", best_sad, 32'd50);
    chk("idle_spur_idx", {30'b0, best_idx}, 32'd2);
    chk("idle_spur_cand", {30'b0, cand_idx}, 32'd3);
    search('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 32'hFFFF_FFFF, 2'd0, 1'b0, -1);
    search('{32'd500, 32'd200, 32'd300, 32'd900}, 32'd200, 2'd1, 1'b1, -1);
    search('{32'd500, 32'd200, 32'd300, 32'd900}, 32'd0, 2'd0, 1'b0, 2);
    search('{32'd10, 32'd5, 32'd8, 32'd9}, 32'd5, 2'd1, 1'b0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
